// File: rtl/sha256_serial_host_if.sv
// Host-side byte handshakes of the SHA-256 serial host: message bytes in, digest bytes out.
interface sha256_serial_host_if;
    logic [7:0] msg_byte;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] dig_byte;
    logic       dig_valid;
    logic       dig_ready;

    modport master (
        output msg_byte, msg_valid, dig_ready,
        input  msg_ready, dig_byte, dig_valid
    );
    modport slave (
        input  msg_byte, msg_valid, dig_ready,
        output msg_ready, dig_byte, dig_valid
    );
endinterface

// File: rtl/sha256_serial_host.sv
// Bridges a byte-wide host to a bit-serial SHA-256 core: serialises one 512-bit block,
// starts the core, waits for the digest with a timeout and streams the 32 digest bytes back.
module sha256_serial_host #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    sha256_serial_host_if.slave host,
    output logic               sdo,
    output logic               sdo_en,
    output logic               blk_start,
    input  logic               core_done,
    input  logic               sdi,
    output logic               sdi_en,
    output logic               busy,
    output logic               err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, START, WAIT, READ, HOLD} state_t;

    state_t        state, state_nxt;
    logic [5:0]    byte_cnt;
    logic [2:0]    bit_cnt;
    logic [4:0]    dig_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    msg_sr;
    logic [7:0]    dig_sr;
    logic          msg_hs;
    logic          dig_hs;

    // msg_ready is already gated by ena, so a message handshake implies ena
    assign msg_hs = host.msg_valid && host.msg_ready;
    assign dig_hs = ena && (state == HOLD) && host.dig_valid && host.dig_ready;

    always_ff @(posedge clk) begin
        if (!rst_n)   state <= IDLE;
        else if (ena) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, LOAD: if (msg_hs) state_nxt = SHIFT;
            SHIFT:      if (bit_cnt == 3'd7) state_nxt = (byte_cnt == 6'd63) ? START : LOAD;
            START:      state_nxt = WAIT;
            WAIT: begin
                if (core_done)                state_nxt = READ;
                else if (tmo_cnt == TMO_LAST) state_nxt = IDLE;
            end
            READ:       if (bit_cnt == 3'd7) state_nxt = HOLD;
            HOLD:       if (dig_hs) state_nxt = (dig_cnt == 5'd31) ? IDLE : READ;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        host.msg_ready = 1'b0;
        sdo_en         = 1'b0;
        blk_start      = 1'b0;
        sdi_en         = 1'b0;
        if (ena) begin
            case (state)
                IDLE, LOAD: host.msg_ready = 1'b1;
                SHIFT:      sdo_en         = 1'b1;
                START:      blk_start      = 1'b1;
                READ:       sdi_en         = 1'b1;
                default:    ;
            endcase
        end
    end

    assign sdo  = sdo_en & msg_sr[7];
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt       <= '0;
            bit_cnt        <= '0;
            dig_cnt        <= '0;
            tmo_cnt        <= '0;
            msg_sr         <= '0;
            dig_sr         <= '0;
            host.dig_byte  <= '0;
            host.dig_valid <= 1'b0;
            err            <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: if (msg_hs) begin
                    msg_sr   <= host.msg_byte;
                    byte_cnt <= '0;
                    bit_cnt  <= '0;
                    err      <= 1'b0;
                end
                LOAD: if (msg_hs) begin
                    msg_sr  <= host.msg_byte;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    msg_sr  <= {msg_sr[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7 && byte_cnt != 6'd63) byte_cnt <= byte_cnt + 6'd1;
                end
                START: tmo_cnt <= '0;
                WAIT: begin
                    if (core_done) begin
                        dig_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                        if (tmo_cnt == TMO_LAST) err <= 1'b1;
                    end
                end
                READ: begin
                    // sdi lands in the LSB so the first digest bit ends up as bit 7
                    dig_sr  <= {dig_sr[6:0], sdi};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        host.dig_byte  <= {dig_sr[6:0], sdi};
                        host.dig_valid <= 1'b1;
                    end
                end
                HOLD: if (dig_hs) begin
                    host.dig_valid <= 1'b0;
                    if (dig_cnt != 5'd31) dig_cnt <= dig_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_serial_host.sv
// Bench for sha256_serial_host: behavioural SHA-256 core model on the serial side,
// directed host sequences with random blocks, digests checked against a reference compression.
module tb_sha256_serial_host;
    logic clk = 1'b0;
    logic rst_n, ena, sdo, sdo_en, blk_start, core_done, sdi, sdi_en, busy, err;

    sha256_serial_host_if host_if ();

    sha256_serial_host #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .host(host_if.slave),
        .sdo(sdo), .sdo_en(sdo_en), .blk_start(blk_start), .core_done(core_done),
        .sdi(sdi), .sdi_en(sdi_en), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One SHA-256 compression of a single block from the standard initial hash value
    function automatic logic [255:0] sha_blk(input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        a = 32'h6a09e667; b = 32'hbb67ae85; c = 32'h3c6ef372; d = 32'ha54ff53a;
        e = 32'h510e527f; f = 32'h9b05688c; g = 32'h1f83d9ab; h = 32'h5be0cd19;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {32'h6a09e667 + a, 32'hbb67ae85 + b, 32'h3c6ef372 + c, 32'ha54ff53a + d,
                32'h510e527f + e, 32'h9b05688c + f, 32'h1f83d9ab + g, 32'h5be0cd19 + h};
    endfunction

    // Serial core model: collects sdo bits, hashes on blk_start, raises core_done after a latency
    logic [511:0] core_blk = '0;
    logic [255:0] core_dig = '0;
    int core_nbits = 0, core_bits_at_start = 0, core_rd = 0, core_cnt = -1, n_start = 0;
    logic core_never = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            core_nbits <= 0;
            core_done  <= 1'b0;
            core_rd    <= 0;
            core_cnt   <= -1;
        end else begin
            if (sdo_en) begin
                core_blk   <= {core_blk[510:0], sdo};
                core_nbits <= core_nbits + 1;
            end
            if (blk_start) begin
                core_dig           <= sha_blk(core_blk);
                core_bits_at_start <= core_nbits;
                core_nbits         <= 0;
                core_done          <= 1'b0;
                core_rd            <= 0;
                n_start            <= n_start + 1;
                core_cnt           <= core_never ? -1 : int'($urandom_range(1, 10));
            end else if (core_cnt > 0) begin
                core_cnt <= core_cnt - 1;
            end else if (core_cnt == 0) begin
                core_done <= 1'b1;
                core_cnt  <= -1;
            end
            if (sdi_en) core_rd <= core_rd + 1;
        end
    end

    assign sdi = (core_rd < 256) ? core_dig[8'(255 - core_rd)] : 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_msg_ready", host_if.msg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_dig_valid", host_if.dig_valid, 0);
        chk("rst_dig_byte", host_if.dig_byte, 0);
        chk("rst_sdo", sdo, 0);
        chk("rst_sdo_en", sdo_en, 0);
        chk("rst_sdi_en", sdi_en, 0);
        chk("rst_blk_start", blk_start, 0);
    endtask

    // Called and returns at a falling edge
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        host_if.msg_valid = 1'b1;
        host_if.msg_byte  = b;
        while (host_if.msg_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("msg_ready_wait", host_if.msg_ready, 1);
        @(negedge clk);
        host_if.msg_valid = 1'b0;
        host_if.msg_byte  = 8'h00;
    endtask

    task automatic send_range(input logic [511:0] blk, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_byte(blk[511 - 8*i -: 8]);
    endtask

    task automatic read_digest(input int stall_at, input int ena_at, output logic [255:0] dig);
        int n, rd0;
        logic [7:0] b;
        dig = '0;
        for (int i = 0; i < 32; i++) begin
            n = 0;
            while (host_if.dig_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
            chk("dig_valid_wait", host_if.dig_valid, 1);
            b = host_if.dig_byte;
            if (i == stall_at) begin
                rd0 = core_rd;
                repeat (20) begin
                    @(negedge clk);
                    chk("stall_dig_byte", host_if.dig_byte, b);
                    chk("stall_sdi_en", sdi_en, 0);
                end
                chk("stall_bits_consumed", core_rd, rd0);
            end
            dig[255 - 8*i -: 8] = b;
            host_if.dig_ready = 1'b1;
            @(negedge clk);
            host_if.dig_ready = 1'b0;
            chk("dig_valid_drop", host_if.dig_valid, 0);
            if (i == ena_at) begin
                @(negedge clk);
                rd0 = core_rd;
                ena = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("ena_sdi_en", sdi_en, 0);
                    chk("ena_msg_ready", host_if.msg_ready, 0);
                    chk("ena_busy", busy, 1);
                end
                chk("ena_bits_frozen", core_rd, rd0);
                ena = 1'b1;
            end
        end
    endtask

    task automatic rand_block(output logic [511:0] blk);
        for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] abc, rnd;
        logic [255:0] dig;
        logic [7:0]   pat;
        int           n0, n;

        abc = {24'h616263, 8'h80, 416'h0, 64'h18};
        rst_n = 1'b0; ena = 1'b1; core_never = 1'b0;
        host_if.msg_valid = 1'b0; host_if.msg_byte = 8'h00; host_if.dig_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        // single byte serialisation, MSB first
        pat = 8'hA5;
        host_if.msg_valid = 1'b1; host_if.msg_byte = pat;
        @(negedge clk);
        host_if.msg_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("a5_sdo_en", sdo_en, 1);
            chk("a5_sdo", sdo, pat[7 - k]);
            chk("a5_msg_ready", host_if.msg_ready, 0);
            @(negedge clk);
        end
        chk("a5_load_sdo_en", sdo_en, 0);
        chk("a5_load_ready", host_if.msg_ready, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // padded "abc" with a stalled digest byte and an enable drop mid-READ
        n0 = n_start;
        send_range(abc, 0, 63);
        read_digest(5, 10, dig);
        chk("abc_digest", dig, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        chk("abc_one_start", n_start - n0, 1);
        chk("abc_bits", core_bits_at_start, 512);
        chk("abc_block_seen", core_blk, abc);
        chk("abc_idle", busy, 0);

        // reset during SHIFT of byte 30
        rand_block(rnd);
        n0 = n_start;
        send_range(rnd, 0, 29);
        host_if.msg_valid = 1'b1; host_if.msg_byte = rnd[511 - 8*30 -: 8];
        n = 0;
        while (host_if.msg_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        host_if.msg_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("b30_in_shift", sdo_en, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("b30_no_start", n_start - n0, 0);
        chk("b30_no_dig", host_if.dig_valid, 0);

        rand_block(rnd);
        n0 = n_start;
        send_range(rnd, 0, 63);
        read_digest(-1, -1, dig);
        chk("rnd_digest", dig, sha_blk(rnd));
        chk("rnd_one_start", n_start - n0, 1);

        // timeout: core never finishes
        core_never = 1'b1;
        rand_block(rnd);
        send_range(rnd, 0, 63);
        n = 0;
        while (blk_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("tmo_start_seen", blk_start, 1);
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        chk("tmo_wait_cycles", n, 16);
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_no_dig", host_if.dig_valid, 0);
        repeat (5) @(negedge clk);
        chk("tmo_err_sticky", err, 1);

        core_never = 1'b0;
        rand_block(rnd);
        send_byte(rnd[511 -: 8]);
        chk("tmo_err_cleared", err, 0);
        send_range(rnd, 1, 63);
        read_digest(-1, 20, dig);
        chk("post_tmo_digest", dig, sha_blk(rnd));
        chk("post_tmo_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
